// File: rtl/pc_ctx_sched_pkg.sv
// Shared types and constants for the multi-context program counter.
// Holds the FSM state enum and the context-index width helper.
package pc_pkg;

  localparam int DEF_QUANTUM = 11;
  localparam int DEF_IO_WAIT = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IOWAIT = 2'd1,
    SWITCH = 2'd2
  } pcState_e;

  // A single-context build still needs a one-bit index.
  function automatic int ctxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_ctx_sched_if.sv
// Bus between fetch/IO logic and the context scheduler.
// io_in|io_out is a level request held until the scheduler resolves it; insert is a per-cycle strobe consumed only while waiting on I/O.
interface pc_ctx_sched_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_CTX = 4
);
  import pc_pkg::*;

  localparam int CTX_W = ctxW(NUM_CTX);

  logic               io_in;
  logic               io_out;
  logic               insert;
  logic               in_program;
  logic [NUM_CTX-1:0] ctx_enable;
  logic [ADDR_W-1:0]  addr_next;
  logic [ADDR_W-1:0]  addr_out;
  logic [CTX_W-1:0]   ctx_id;
  logic               ctx_switch;
  pcState_e           dbgState;

  modport master (
    output io_in, io_out, insert, in_program, ctx_enable, addr_next,
    input  addr_out, ctx_id, ctx_switch, dbgState
  );

  modport slave (
    input  io_in, io_out, insert, in_program, ctx_enable, addr_next,
    output addr_out, ctx_id, ctx_switch, dbgState
  );

endinterface

// File: rtl/pc_ctx_sched_rr_next_ctx.sv
// Combinational round-robin picker: first set mask bit strictly after cur, wrapping.
// cur itself is never chosen; valid=0 when no other context is set.
module rr_next_ctx
  import pc_pkg::*;
#(
  parameter  int NUM_CTX = 4,
  localparam int CTX_W   = ctxW(NUM_CTX)
) (
  input  logic [CTX_W-1:0]   cur,
  input  logic [NUM_CTX-1:0] mask,
  output logic [CTX_W-1:0]   nxt,
  output logic               valid
);

  logic [CTX_W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    nxt   = cur;
    idx   = '0;
    for (int k = 1; k < NUM_CTX; k++) begin
      idx = CTX_W'((int'(cur) + k) % NUM_CTX);
      if (!valid && mask[idx]) begin
        valid = 1'b1;
        nxt   = idx;
      end
    end
  end

endmodule

// File: rtl/pc_ctx_sched.sv
// Multi-context PC with round-robin time slicing of user code and an I/O insert stall.
// Kernel code (in_program=0) is never preempted; I/O requests take priority over an expired slice.
module pc_ctx_sched
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          NUM_CTX    = 4,
  parameter int          QUANTUM    = DEF_QUANTUM,
  parameter int          IO_WAIT    = DEF_IO_WAIT,
  parameter int unsigned CTX_STRIDE = 32'h400
) (
  input logic           CLK,
  input logic           reset,
  pc_ctx_sched_if.slave bus
);

  localparam int CTX_W = ctxW(NUM_CTX);
  localparam int SW    = $clog2(QUANTUM + 1);
  localparam int WW    = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;
  localparam logic [SW-1:0] SLICE_MAX = SW'(QUANTUM);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(IO_WAIT);

  pcState_e          state, stateN;
  logic [ADDR_W-1:0] addrOut, addrN;
  logic [CTX_W-1:0]  ctxId, ctxIdN, pickNxt;
  logic              ctxSwitch, switchN, pickValid, saveEn, ioReq;
  logic [SW-1:0]     sliceCnt, sliceN;
  logic [WW-1:0]     waitCnt, waitN;
  logic [ADDR_W-1:0] ctxPc [NUM_CTX];

  rr_next_ctx #(.NUM_CTX(NUM_CTX)) uPick (
    .cur   (ctxId),
    .mask  (bus.ctx_enable),
    .nxt   (pickNxt),
    .valid (pickValid)
  );

  assign ioReq = bus.io_in | bus.io_out;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= RUN;
      addrOut   <= '0;
      ctxId     <= '0;
      ctxSwitch <= 1'b0;
      sliceCnt  <= '0;
      waitCnt   <= '0;
      for (int i = 0; i < NUM_CTX; i++) ctxPc[i] <= ADDR_W'(CTX_STRIDE * 32'(i));
    end else begin
      state     <= stateN;
      addrOut   <= addrN;
      ctxId     <= ctxIdN;
      ctxSwitch <= switchN;
      sliceCnt  <= sliceN;
      waitCnt   <= waitN;
      if (saveEn) ctxPc[ctxId] <= addrOut;
    end
  end

  always_comb begin
    stateN  = state;
    addrN   = addrOut;
    ctxIdN  = ctxId;
    switchN = 1'b0;
    sliceN  = sliceCnt;
    waitN   = waitCnt;
    saveEn  = 1'b0;
    unique case (state)
      RUN: begin
        if (ioReq) begin
          stateN = IOWAIT;
          waitN  = '0;
        end else if (!bus.in_program) begin
          addrN  = bus.addr_next;
          sliceN = '0;
        end else if (sliceCnt < SLICE_MAX) begin
          addrN  = bus.addr_next;
          sliceN = sliceCnt + 1'b1;
        end else begin
          stateN = SWITCH;
        end
      end
      SWITCH: begin
        if (pickValid) begin
          saveEn  = 1'b1;
          addrN   = ctxPc[pickNxt];
          ctxIdN  = pickNxt;
          switchN = 1'b1;
        end
        sliceN = '0;
        stateN = RUN;
      end
      IOWAIT: begin
        if (!ioReq) begin
          stateN = RUN;
          waitN  = '0;
        end else if (bus.insert) begin
          if (waitCnt < WAIT_MAX) begin
            waitN = waitCnt + 1'b1;
          end else begin
            addrN  = bus.addr_next;
            waitN  = '0;
            stateN = RUN;
            // Saturate: a slice that expired before the I/O stays expired so the deferred switch still happens.
            if (bus.in_program && sliceCnt < SLICE_MAX) sliceN = sliceCnt + 1'b1;
          end
        end
      end
      default: stateN = RUN;
    endcase
  end

  assign bus.addr_out   = addrOut;
  assign bus.ctx_id     = ctxId;
  assign bus.ctx_switch = ctxSwitch;
  assign bus.dbgState   = state;

endmodule

// File: tb/tb_pc_ctx_sched.sv
// Bench for pc_ctx_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_ctx_sched;
  import pc_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int NUM_CTX = 4;
  localparam int QUANTUM = 11;
  localparam int IO_WAIT = 5;
  localparam int CTX_W   = 2;
  localparam int W       = ADDR_W + CTX_W + 3;

  // clock / reset
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  pc_ctx_sched_if #(.ADDR_W(ADDR_W), .NUM_CTX(NUM_CTX)) bus ();

  pc_ctx_sched #(
    .ADDR_W(ADDR_W), .NUM_CTX(NUM_CTX), .QUANTUM(QUANTUM),
    .IO_WAIT(IO_WAIT), .CTX_STRIDE(32'h400)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nTests = 0;
  int nFail  = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model: phase flags instead of a state encoding
  logic [ADDR_W-1:0] mPc;
  logic [ADDR_W-1:0] mSaved [NUM_CTX];
  int mCtx, mSlice, mWaited;
  bit mInIo, mSwitchDue, mPulse;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int cand;
    mPulse = 1'b0;
    if (!reset) begin
      mPc = '0; mCtx = 0; mSlice = 0; mWaited = 0; mInIo = 0; mSwitchDue = 0;
      for (int i = 0; i < NUM_CTX; i++) mSaved[i] = ADDR_W'(i * 32'h400);
    end else if (mSwitchDue) begin
      cand = -1;
      for (int k = 1; k < NUM_CTX; k++)
        if (cand < 0 && bus.ctx_enable[(mCtx + k) % NUM_CTX]) cand = (mCtx + k) % NUM_CTX;
      if (cand >= 0) begin
        mSaved[mCtx] = mPc;
        mPc = mSaved[cand];
        mCtx = cand;
        mPulse = 1'b1;
      end
      mSlice = 0;
      mSwitchDue = 0;
    end else if (mInIo) begin
      if (!(bus.io_in || bus.io_out)) begin
        mInIo = 0; mWaited = 0;
      end else if (bus.insert) begin
        if (mWaited < IO_WAIT) mWaited++;
        else begin
          mPc = bus.addr_next;
          if (bus.in_program && mSlice < QUANTUM) mSlice++;
          mWaited = 0;
          mInIo = 0;
        end
      end
    end else if (bus.io_in || bus.io_out) begin
      mInIo = 1; mWaited = 0;
    end else if (!bus.in_program) begin
      mPc = bus.addr_next; mSlice = 0;
    end else if (mSlice < QUANTUM) begin
      mPc = bus.addr_next; mSlice++;
    end else begin
      mSwitchDue = 1;
    end
  endtask

  task automatic tick();
    logic [W-1:0] e;
    pcState_e st;
    model_step();
    st = mInIo ? IOWAIT : (mSwitchDue ? SWITCH : RUN);
    exp_q.push_back({st, mPulse, CTX_W'(mCtx), mPc});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("addr_out",   bus.addr_out,   e[ADDR_W-1:0]);
    check("ctx_id",     bus.ctx_id,     e[ADDR_W +: CTX_W]);
    check("ctx_switch", bus.ctx_switch, e[ADDR_W+CTX_W]);
    check("state",      bus.dbgState,   e[W-1 -: 2]);
  endtask

  // driver tasks
  task automatic drive(input bit ioIn, input bit ioOut, input bit ins, input bit prog,
                       input logic [NUM_CTX-1:0] en, input logic [ADDR_W-1:0] nxt);
    bus.io_in = ioIn; bus.io_out = ioOut; bus.insert = ins;
    bus.in_program = prog; bus.ctx_enable = en; bus.addr_next = nxt;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), NUM_CTX'($urandom), $urandom);
  endtask

  task automatic user_steps(input int n);
    for (int i = 0; i < n; i++) begin
      bus.addr_next = bus.addr_out + 32'd4;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int visits, pulses, updates;
    logic [ADDR_W-1:0] prevAddr;

    // 1: reset with random inputs
    reset = 1'b0;
    drive_random(); tick();
    drive_random(); tick();
    check("rst_addr", bus.addr_out, 0);
    check("rst_ctx", bus.ctx_id, 0);
    check("rst_sw", bus.ctx_switch, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 4'b0011, 32'h10);
    tick();
    check("t1_addr", bus.addr_out, 32'h10);

    // 2: two-context round robin
    reset = 1'b0; tick(); reset = 1'b1;
    drive(0, 0, 0, 1, 4'b0011, 32'h0);
    user_steps(QUANTUM);
    check("t2_slice_end", bus.addr_out, 32'h2C);
    tick();
    check("t2_in_switch", bus.dbgState, SWITCH);
    tick();
    check("t2_sw1", bus.ctx_switch, 1);
    check("t2_ctx1", bus.ctx_id, 1);
    check("t2_load1", bus.addr_out, 32'h400);
    user_steps(QUANTUM);
    check("t2_slice2_end", bus.addr_out, 32'h42C);
    tick(); tick();
    check("t2_ctx0", bus.ctx_id, 0);
    check("t2_load0", bus.addr_out, 32'h2C);

    // 3: full I/O wait
    drive(1, 0, 1, 0, 4'b0011, 32'h80);
    for (int i = 0; i < IO_WAIT + 1; i++) begin
      tick();
      check("t3_frozen", bus.addr_out, 32'h2C);
    end
    tick();
    check("t3_resume", bus.addr_out, 32'h80);
    check("t3_run", bus.dbgState, RUN);

    // 4: aborted I/O, then a fresh full wait
    drive(0, 1, 1, 0, 4'b0011, 32'h88);
    for (int i = 0; i < 4; i++) tick();
    bus.io_out = 1'b0;
    tick();
    check("t4_abort_addr", bus.addr_out, 32'h80);
    check("t4_abort_run", bus.dbgState, RUN);
    drive(0, 1, 1, 0, 4'b0011, 32'h90);
    for (int i = 0; i < IO_WAIT + 1; i++) begin
      tick();
      check("t4_frozen", bus.addr_out, 32'h80);
    end
    tick();
    check("t4_resume", bus.addr_out, 32'h90);
    bus.io_out = 1'b0;

    // 5: only one context enabled
    drive(0, 0, 0, 0, 4'b0001, 32'h100);
    tick();
    bus.in_program = 1'b1;
    visits = 0; pulses = 0; updates = 0;
    for (int i = 0; i < 34; i++) begin
      prevAddr = bus.addr_out;
      bus.addr_next = bus.addr_out + 32'd4;
      tick();
      if (bus.dbgState == SWITCH) visits++;
      if (bus.ctx_switch) pulses++;
      if (bus.addr_out != prevAddr) updates++;
    end
    check("t5_updates", updates, 30);
    check("t5_visits", visits, 2);
    check("t5_pulses", pulses, 0);
    check("t5_ctx", bus.ctx_id, 0);
    bus.in_program = 1'b0;
    visits = 0;
    for (int i = 0; i < 50; i++) begin
      bus.addr_next = $urandom;
      tick();
      if (bus.dbgState == SWITCH || bus.ctx_switch) visits++;
    end
    check("t5_kernel_noswitch", visits, 0);

    // 6: reset in SWITCH and in IOWAIT
    drive(0, 0, 0, 1, 4'b0011, 32'h0);
    user_steps(QUANTUM);
    tick();
    check("t6_in_switch", bus.dbgState, SWITCH);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_rst1_addr", bus.addr_out, 0);
    check("t6_rst1_state", bus.dbgState, RUN);
    check("t6_rst1_sw", bus.ctx_switch, 0);
    drive(1, 0, 1, 1, 4'b0011, 32'h200);
    for (int i = 0; i < 4; i++) tick();
    check("t6_in_iowait", bus.dbgState, IOWAIT);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_rst2_addr", bus.addr_out, 0);
    check("t6_rst2_state", bus.dbgState, RUN);
    drive(0, 0, 0, 1, 4'b0011, 32'h0);
    user_steps(QUANTUM);
    tick(); tick();
    check("t6_reload_ctx", bus.ctx_id, 1);
    check("t6_reload_pc", bus.addr_out, 32'h400);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) bus.io_in = ~bus.io_in;
      if ($urandom_range(0, 11) == 0) bus.io_out = ~bus.io_out;
      bus.insert = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) bus.in_program = ~bus.in_program;
      if ($urandom_range(0, 19) == 0) bus.ctx_enable = NUM_CTX'($urandom);
      bus.addr_next = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
